// File: rtl/router_pkg.sv
// Shared definitions for the response return path: source tag encoding and default widths.
package router_pkg;

   // Same encoding as the arbiter's data_out_ready; tag value 3 is never issued.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_1    = 2'd1,
      SRC_2    = 2'd2
   } src_t;

   localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/router_fifo.sv
// Synchronous first-word-fall-through FIFO with a clear input that empties it in one edge.
module router_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  logic [DATA_W-1:0]            data_in,
   output logic [DATA_W-1:0]            data_out,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int PW    = $clog2(DEPTH) + 1;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign level    = LVL_W'(wr_ptr - rd_ptr);
   assign do_push  = push && !full && !clear;
   assign do_pop   = pop && !empty && !clear;
   assign data_out = empty ? '0 : mem[rd_ptr[PW-2:0]];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-2:0]] <= data_in;
   end

endmodule

// File: rtl/response_router.sv
// Return path for core results: routes each tagged result into the FIFO of the source that issued it.
module response_router
   import router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_W-1:0]           resp_data,
   input  logic [1:0]                  resp_src,
   input  logic                        resp_valid,
   output logic                        resp_ready,
   input  logic                        flush_1,
   output logic [DATA_W-1:0]           result_1,
   output logic                        result_valid_1,
   input  logic                        result_ready_1,
   output logic [DATA_W-1:0]           result_2,
   output logic                        result_valid_2,
   input  logic                        result_ready_2,
   output logic [$clog2(DEPTH+1)-1:0]  level_1,
   output logic [$clog2(DEPTH+1)-1:0]  level_2,
   output logic [CNT_W-1:0]            bad_src_cnt
);

   logic full_1, full_2, empty_1, empty_2;
   logic accept, push_1, push_2, bad_tag;

   // Handshake: a transfer happens on an edge where valid and ready are both high; valid
   // never waits on ready, and ready here is a function of registered FIFO state only.
   assign resp_ready = !full_1 && !full_2;
   assign accept     = resp_valid && resp_ready;
   assign push_1     = accept && (resp_src == SRC_1);
   assign push_2     = accept && (resp_src == SRC_2);
   assign bad_tag    = accept && (resp_src != SRC_1) && (resp_src != SRC_2);

   assign result_valid_1 = !empty_1;
   assign result_valid_2 = !empty_2;

   router_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
      .clk      (clk),
      .reset    (reset),
      .push     (push_1),
      .pop      (result_ready_1),
      .clear    (flush_1),
      .data_in  (resp_data),
      .data_out (result_1),
      .full     (full_1),
      .empty    (empty_1),
      .level    (level_1)
   );

   router_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
      .clk      (clk),
      .reset    (reset),
      .push     (push_2),
      .pop      (result_ready_2),
      .clear    (1'b0),
      .data_in  (resp_data),
      .data_out (result_2),
      .full     (full_2),
      .empty    (empty_2),
      .level    (level_2)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         bad_src_cnt <= '0;
      end else if (bad_tag && (bad_src_cnt != '1)) begin
         bad_src_cnt <= bad_src_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_response_router.sv
// Self-checking bench for response_router: directed scenarios plus a randomized run against a queue model.
module tb_response_router;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 8;
   localparam int LW     = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] resp_data;
   logic [1:0]        resp_src;
   logic              resp_valid;
   logic              resp_ready;
   logic              flush_1;
   logic [DATA_W-1:0] result_1, result_2;
   logic              result_valid_1, result_valid_2;
   logic              result_ready_1, result_ready_2;
   logic [LW-1:0]     level_1, level_2;
   logic [CNT_W-1:0]  bad_src_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: one queue per source plus the saturating bad-tag count.
   logic [DATA_W-1:0] m_q1[$];
   logic [DATA_W-1:0] m_q2[$];
   int                m_bad = 0;

   always #5 clk = ~clk;

   response_router #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .resp_data      (resp_data),
      .resp_src       (resp_src),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .flush_1        (flush_1),
      .result_1       (result_1),
      .result_valid_1 (result_valid_1),
      .result_ready_1 (result_ready_1),
      .result_2       (result_2),
      .result_valid_2 (result_valid_2),
      .result_ready_2 (result_ready_2),
      .level_1        (level_1),
      .level_2        (level_2),
      .bad_src_cnt    (bad_src_cnt)
   );

   // Advance the model by one edge using the inputs currently driven, then move to the next negedge.
   task automatic step();
      bit rdy, acc;
      if (reset) begin
         m_q1.delete();
         m_q2.delete();
         m_bad = 0;
      end else begin
         rdy = (m_q1.size() < DEPTH) && (m_q2.size() < DEPTH);
         acc = resp_valid && rdy;
         if (flush_1) begin
            m_q1.delete();
         end else begin
            if (result_ready_1 && m_q1.size() > 0) void'(m_q1.pop_front());
            if (acc && resp_src == 2'd1) m_q1.push_back(resp_data);
         end
         if (result_ready_2 && m_q2.size() > 0) void'(m_q2.pop_front());
         if (acc && resp_src == 2'd2) m_q2.push_back(resp_data);
         if (acc && (resp_src == 2'd0 || resp_src == 2'd3) && m_bad < 255) m_bad++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [DATA_W-1:0] d,
                        input logic r1, input logic r2, input logic f);
      resp_valid     = v;
      resp_src       = s;
      resp_data      = d;
      result_ready_1 = r1;
      result_ready_2 = r2;
      flush_1        = f;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 2'd0, '0, 0, 0, 0);
      step();
      step();
      reset = 1'b0;
      checks++;
      if ({resp_ready, result_valid_1, result_valid_2, level_1, level_2, bad_src_cnt} !==
          {1'b1, 1'b0, 1'b0, LW'(0), LW'(0), CNT_W'(0)}) begin
         errors++;
         $display("FAIL reset_state: got rdy=%0b v1=%0b v2=%0b l1=%0d l2=%0d bad=%0d, want 1 0 0 0 0 0",
                  resp_ready, result_valid_1, result_valid_2, level_1, level_2, bad_src_cnt);
      end
      checks++;
      if (result_1 !== '0 || result_2 !== '0) begin
         errors++;
         $display("FAIL reset_results: got r1=%h r2=%h, want 0 0", result_1, result_2);
      end
   endtask

   task automatic test_order();
      drive(1, 2'd1, 32'h11, 0, 0, 0);
      step();
      drive(1, 2'd1, 32'h22, 0, 0, 0);
      step();
      drive(0, 2'd0, '0, 0, 0, 0);
      checks++;
      if (level_1 !== LW'(2) || result_1 !== 32'h11 || result_valid_1 !== 1'b1) begin
         errors++;
         $display("FAIL order_buffered: got l1=%0d r1=%h v1=%0b, want 2 00000011 1",
                  level_1, result_1, result_valid_1);
      end
      result_ready_1 = 1'b1;
      step();
      checks++;
      if (result_1 !== 32'h22 || result_valid_1 !== 1'b1) begin
         errors++;
         $display("FAIL order_second: got r1=%h v1=%0b, want 00000022 1", result_1, result_valid_1);
      end
      step();
      checks++;
      if (result_valid_1 !== 1'b0 || result_1 !== '0 || level_1 !== LW'(0)) begin
         errors++;
         $display("FAIL order_drained: got v1=%0b r1=%h l1=%0d, want 0 0 0",
                  result_valid_1, result_1, level_1);
      end
      result_ready_1 = 1'b0;
   endtask

   task automatic test_interleave();
      logic [1:0]        tags [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
      logic [DATA_W-1:0] dat  [4] = '{32'hA1, 32'hB1, 32'hA2, 32'hB2};
      logic [DATA_W-1:0] exp1 [5] = '{32'hA1, 32'h0, 32'hA2, 32'h0, 32'h0};
      logic [DATA_W-1:0] exp2 [5] = '{32'h0, 32'hB1, 32'h0, 32'hB2, 32'h0};
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(1, tags[i], dat[i], 1, 1, 0);
         else       drive(0, 2'd0, '0, 1, 1, 0);
         step();
         checks++;
         if (result_1 !== exp1[i] || result_valid_1 !== (exp1[i] != 0) ||
             result_2 !== exp2[i] || result_valid_2 !== (exp2[i] != 0)) begin
            errors++;
            $display("FAIL interleave_%0d: got v1=%0b r1=%h v2=%0b r2=%h, want r1=%h r2=%h",
                     i, result_valid_1, result_1, result_valid_2, result_2, exp1[i], exp2[i]);
         end
      end
      drive(0, 2'd0, '0, 0, 0, 0);
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'd2, 32'hF0 + i, 0, 0, 0);
         checks++;
         if (resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_fill_%0d: got resp_ready=%0b, want 1", i, resp_ready);
         end
         step();
      end
      drive(1, 2'd2, 32'hF4, 0, 0, 0);
      checks++;
      if (resp_ready !== 1'b0 || level_2 !== LW'(4)) begin
         errors++;
         $display("FAIL full_blocked: got rdy=%0b l2=%0d, want 0 4", resp_ready, level_2);
      end
      step();
      result_ready_2 = 1'b1;
      checks++;
      if (resp_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_no_bypass: got rdy=%0b, want 0", resp_ready);
      end
      step();
      result_ready_2 = 1'b0;
      checks++;
      if (resp_ready !== 1'b1 || level_2 !== LW'(3)) begin
         errors++;
         $display("FAIL full_reopen: got rdy=%0b l2=%0d, want 1 3", resp_ready, level_2);
      end
      step();
      drive(0, 2'd0, '0, 0, 1, 0);
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (result_2 !== 32'hF0 + i || result_valid_2 !== 1'b1) begin
            errors++;
            $display("FAIL full_drain_%0d: got v2=%0b r2=%h, want 1 %h",
                     i, result_valid_2, result_2, 32'hF0 + i);
         end
         step();
      end
      checks++;
      if (result_valid_2 !== 1'b0 || level_2 !== LW'(0)) begin
         errors++;
         $display("FAIL full_empty: got v2=%0b l2=%0d, want 0 0", result_valid_2, level_2);
      end
      drive(0, 2'd0, '0, 0, 0, 0);
   endtask

   task automatic test_flush();
      drive(1, 2'd2, 32'hC1, 0, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'd1, 32'hD0 + i, 0, 0, 0);
         step();
      end
      drive(1, 2'd1, 32'h99, 1, 0, 1);
      step();
      drive(0, 2'd0, '0, 0, 0, 0);
      checks++;
      if (level_1 !== LW'(0) || result_valid_1 !== 1'b0 || result_1 !== '0) begin
         errors++;
         $display("FAIL flush_cleared: got l1=%0d v1=%0b r1=%h, want 0 0 0",
                  level_1, result_valid_1, result_1);
      end
      checks++;
      if (level_2 !== LW'(1) || result_2 !== 32'hC1) begin
         errors++;
         $display("FAIL flush_fifo2_intact: got l2=%0d r2=%h, want 1 000000c1", level_2, result_2);
      end
      drive(0, 2'd0, '0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (result_valid_1 !== 1'b0 || result_1 === 32'h99) begin
            errors++;
            $display("FAIL flush_no_ghost_%0d: got v1=%0b r1=%h, want 0", i, result_valid_1, result_1);
         end
      end
      drive(0, 2'd0, '0, 0, 0, 0);
   endtask

   task automatic test_bad_tag();
      drive(1, 2'd0, $urandom, 1, 1, 0);
      step();
      drive(1, 2'd3, $urandom, 1, 1, 0);
      step();
      drive(0, 2'd0, '0, 1, 1, 0);
      checks++;
      if (bad_src_cnt !== CNT_W'(2) || result_valid_1 !== 1'b0 || result_valid_2 !== 1'b0) begin
         errors++;
         $display("FAIL bad_tag_count: got bad=%0d v1=%0b v2=%0b, want 2 0 0",
                  bad_src_cnt, result_valid_1, result_valid_2);
      end
      for (int i = 0; i < 300; i++) begin
         drive(1, 2'd3, $urandom, 1, 1, 0);
         step();
         if (i == 252) begin
            checks++;
            if (bad_src_cnt !== CNT_W'(255)) begin
               errors++;
               $display("FAIL bad_tag_reach_max: got %0d, want 255", bad_src_cnt);
            end
         end
      end
      drive(0, 2'd0, '0, 0, 0, 0);
      checks++;
      if (bad_src_cnt !== CNT_W'(255) || level_1 !== LW'(0) || level_2 !== LW'(0)) begin
         errors++;
         $display("FAIL bad_tag_saturate: got bad=%0d l1=%0d l2=%0d, want 255 0 0",
                  bad_src_cnt, level_1, level_2);
      end
   endtask

   task automatic test_reset_mid();
      drive(1, 2'd1, 32'h5A, 0, 0, 0);
      step();
      drive(1, 2'd2, 32'h5B, 0, 0, 0);
      step();
      reset = 1'b1;
      drive(1, 2'd1, 32'h5C, 0, 0, 0);
      step();
      reset = 1'b0;
      drive(0, 2'd0, '0, 0, 0, 0);
      checks++;
      if ({resp_ready, result_valid_1, result_valid_2, level_1, level_2, bad_src_cnt} !==
          {1'b1, 1'b0, 1'b0, LW'(0), LW'(0), CNT_W'(0)}) begin
         errors++;
         $display("FAIL reset_mid: got rdy=%0b v1=%0b v2=%0b l1=%0d l2=%0d bad=%0d, want 1 0 0 0 0 0",
                  resp_ready, result_valid_1, result_valid_2, level_1, level_2, bad_src_cnt);
      end
   endtask

   task automatic test_random();
      logic [80:0] obs, exp;
      int          t;
      for (int i = 0; i < 600; i++) begin
         t = $urandom_range(0, 9);
         drive($urandom_range(0, 3) != 0,
               (t <= 3) ? 2'd1 : (t <= 7) ? 2'd2 : (t == 8) ? 2'd0 : 2'd3,
               $urandom,
               $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
               $urandom_range(0, 15) == 0);
         step();
         obs = {resp_ready, result_valid_1, result_1, level_1,
                result_valid_2, result_2, level_2, bad_src_cnt};
         exp = {(m_q1.size() < DEPTH) && (m_q2.size() < DEPTH),
                m_q1.size() > 0, (m_q1.size() > 0) ? m_q1[0] : 32'h0, LW'(m_q1.size()),
                m_q2.size() > 0, (m_q2.size() > 0) ? m_q2[0] : 32'h0, LW'(m_q2.size()),
                CNT_W'(m_bad)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random_%0d: got %h, want %h", i, obs, exp);
         end
      end
      drive(0, 2'd0, '0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 2'd0, '0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_order();
      test_interleave();
      test_full();
      test_flush();
      test_bad_tag();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
